// File: rtl/booth_restoring_divider_if.sv
// Operand/result bundle shared by the signed divider and its requester.
// Requester drives start/data_in; the divider returns results qualified by done.
interface booth_restoring_divider_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  // start is a one-cycle request, honoured only when busy=0.
  // Dividend then divisor follow on data_in on the next two cycles.
  // quotient/remainder/div_by_zero are valid while done=1, and done holds until the next accepted start.
  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/booth_restoring_divider.sv
// Signed restoring divider: operands loaded serially, sign-magnitude core,
// one quotient bit per cycle, sign fix-up at the end (truncating / and % semantics).
module booth_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  booth_restoring_divider_if.slave        bus,
  output logic [2:0]                      dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_FIXUP  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvsr_neg_q, dvsr_neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Shifted partial remainder is always below 2^WIDTH, so bit WIDTH of diff is a true sign.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    dvd_neg_d  = dvd_neg_q;
    dvsr_neg_d = dvsr_neg_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rmd_d      = rmd_q;
    done_d     = done_q;
    busy_d     = busy_q;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LOAD_A;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
        end
      end
      S_LOAD_A: begin
        dvd_neg_d = bus.data_in[WIDTH-1];
        dvd_d     = bus.data_in[WIDTH-1] ? -bus.data_in : bus.data_in;
        state_d   = S_LOAD_B;
      end
      S_LOAD_B: begin
        dvsr_neg_d = bus.data_in[WIDTH-1];
        dvsr_d     = bus.data_in[WIDTH-1] ? -bus.data_in : bus.data_in;
        if (bus.data_in == '0) begin
          // Remainder reports the dividend exactly as it was presented.
          quo_d   = '1;
          rmd_d   = dvd_neg_q ? -dvd_q : dvd_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        // Magnitude 2^(WIDTH-1) wraps naturally, giving the two's complement overflow result.
        quo_d   = (dvd_neg_q ^ dvsr_neg_q) ? -dvd_q : dvd_q;
        rmd_d   = dvd_neg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      dvd_neg_q  <= 1'b0;
      dvsr_neg_q <= 1'b0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rmd_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      dvd_neg_q  <= dvd_neg_d;
      dvsr_neg_q <= dvsr_neg_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rmd_q      <= rmd_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;

endmodule
